bias_activate: RTL and testbench

- Post-matmul stage for one dense layer. Consumes the packed H*W float32 product vector from matmul, adds a per-element bias vector and applies an activation (none or ReLU).
- Presents the result as one packed vector with a done level for the next layer.
- One shared add_float instance, time-multiplexed across elements, keeps area low.

---
 rtl/bias_activate_pkg.sv | 43 ++++
 rtl/add_float.sv | 139 +++++++++++++
 rtl/bias_activate_float_relu.sv | 31 +++
 rtl/bias_activate.sv | 138 +++++++++++++
 tb/tb_bias_activate.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/bias_activate_pkg.sv
// ============================================================================
// bias_activate_pkg
// Shared state encodings, activation selectors, float field helpers and the
// packed-vector element slicing macro used by the dense-layer datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

// Element k of an S*N packed vector; element 0 sits at the MSB end.
`ifndef BA_ELEM
`define BA_ELEM(vec, k, s, n) vec[(s)*((n)-1-int'(k)) +: (s)]
`endif

package bias_activate_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int ACT_NONE = 0;
  localparam int ACT_RELU = 1;

  // Exponent width for the supported IEEE-754 formats (single by default).
  function automatic int exp_width(input int s);
    return (s == 64) ? 11 : (s == 16) ? 5 : 8;
  endfunction

  function automatic int man_width(input int s);
    return s - 1 - exp_width(s);
  endfunction

  function automatic int sign_bit(input int s);
    return s - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_float.sv
// ============================================================================
// add_float
// IEEE-754 adder/subtractor, round-to-nearest-even, subnormal aware.
// Operands are captured on start; sum/done appear two cycles after start.
// done is a one-cycle pulse. rst_n is synchronous, active-low.
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_float
  import bias_activate_pkg::*;
#(
  parameter int S = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  output logic [S-1:0] sum,
  output logic         done,
  output logic         nan,
  output logic         overflow
);

  localparam int EW = exp_width(S);
  localparam int MW = man_width(S);
  localparam int W  = MW + 4;   // hidden + mantissa + guard/round/sticky
  localparam int XW = EW + 2;   // working exponent with headroom

  logic [S-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic         v_q, v_d, done_q, done_d, nan_q, nan_d, ovf_q, ovf_d;

  logic [S-1:0]  r;
  logic          rn, ro;
  logic          a_nan, b_nan, a_inf, b_inf, s_big, s_sml, sticky, rup;
  logic [XW-1:0] xa, xb, e, dsh;
  logic [W-1:0]  fa, fb, f_big, f_sml, sh;
  logic [W:0]    acc;
  logic [MW+1:0] rm;

  // Single-rounding add of the captured operands.
  always_comb begin
    r = '0; rn = 1'b0; ro = 1'b0;
    s_big = 1'b0; s_sml = 1'b0; sticky = 1'b0; rup = 1'b0;
    e = '0; dsh = '0; f_big = '0; f_sml = '0; sh = '0; acc = '0; rm = '0;
    a_nan = (&a_q[S-2:MW]) && (|a_q[MW-1:0]);
    b_nan = (&b_q[S-2:MW]) && (|b_q[MW-1:0]);
    a_inf = (&a_q[S-2:MW]) && !(|a_q[MW-1:0]);
    b_inf = (&b_q[S-2:MW]) && !(|b_q[MW-1:0]);
    xa = (a_q[S-2:MW] == '0) ? XW'(1) : {2'b00, a_q[S-2:MW]};
    xb = (b_q[S-2:MW] == '0) ? XW'(1) : {2'b00, b_q[S-2:MW]};
    fa = {(a_q[S-2:MW] != '0), a_q[MW-1:0], 3'b000};
    fb = {(b_q[S-2:MW] != '0), b_q[MW-1:0], 3'b000};
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[S-1] != b_q[S-1]))) begin
      r  = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      rn = 1'b1;
    end else if (a_inf) begin
      r = a_q;
    end else if (b_inf) begin
      r = b_q;
    end else begin
      if ({xa, fa} >= {xb, fb}) begin
        s_big = a_q[S-1]; s_sml = b_q[S-1]; e = xa; f_big = fa; f_sml = fb; dsh = xa - xb;
      end else begin
        s_big = b_q[S-1]; s_sml = a_q[S-1]; e = xb; f_big = fb; f_sml = fa; dsh = xb - xa;
      end
      if (dsh >= XW'(W)) begin
        sticky = |f_sml;
      end else begin
        sh     = f_sml >> dsh;
        sticky = |(f_sml & ~({W{1'b1}} << dsh));
      end
      sh[0] = sh[0] | sticky;
      if (s_big == s_sml) begin
        acc = {1'b0, f_big} + {1'b0, sh};
        if (acc[W]) begin
          acc = {1'b0, acc[W:2], acc[1] | acc[0]};
          e   = e + XW'(1);
        end
      end else begin
        acc = {1'b0, f_big} - {1'b0, sh};
      end
      if (acc == '0) begin
        r = {(s_big == s_sml) ? s_big : 1'b0, {(S-1){1'b0}}};
      end else begin
        for (int i = 0; i < W; i++) begin
          if (!acc[W-1] && (e > XW'(1))) begin
            acc = acc << 1;
            e   = e - XW'(1);
          end
        end
        rup = acc[2] & (acc[1] | acc[0] | acc[3]);
        rm  = {1'b0, acc[W-1:3]} + (MW+2)'(rup);
        if (rm[MW+1]) begin
          rm = rm >> 1;
          e  = e + XW'(1);
        end
        if (e >= XW'((1 << EW) - 1)) begin
          r  = {s_big, {EW{1'b1}}, {MW{1'b0}}};
          ro = 1'b1;
        end else begin
          r = {s_big, rm[MW] ? e[EW-1:0] : {EW{1'b0}}, rm[MW-1:0]};
        end
      end
    end
  end

  // Operand capture on start, result registration one cycle later.
  always_comb begin
    a_d    = start ? a : a_q;
    b_d    = start ? {b[S-1] ^ sub, b[S-2:0]} : b_q;
    v_d    = start;
    done_d = v_q;
    sum_d  = v_q ? r  : sum_q;
    nan_d  = v_q ? rn : nan_q;
    ovf_d  = v_q ? ro : ovf_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; sum_q <= '0;
      v_q <= 1'b0; done_q <= 1'b0; nan_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; sum_q <= sum_d;
      v_q <= v_d; done_q <= done_d; nan_q <= nan_d; ovf_q <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign done     = done_q;
  assign nan      = nan_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: rtl/bias_activate_float_relu.sv
// ============================================================================
// float_relu
// Combinational S-bit ReLU: negative values (incl. -0 and -inf) become +0.0,
// NaNs pass through untouched so upstream errors stay visible.
// Revision: 1.0
// ============================================================================
`default_nettype none

module float_relu
  import bias_activate_pkg::*;
#(
  parameter int S = 32
) (
  input  logic [S-1:0] v,
  output logic [S-1:0] r
);

  localparam int MW = man_width(S);
  localparam int SB = sign_bit(S);

  logic is_nan;

  // Clamp negatives to +0 unless the operand is a NaN.
  always_comb begin
    is_nan = (&v[SB-1:MW]) && (|v[MW-1:0]);
    r      = (v[SB] && !is_nan) ? '0 : v;
  end

endmodule

`default_nettype wire

// File: rtl/bias_activate.sv
// ============================================================================
// bias_activate
// Post-matmul stage: y[k] = act(x[k] + bias[k]) for k = 0..N-1, using one
// shared add_float walked across the elements by a small FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bias_activate
  import bias_activate_pkg::*;
#(
  parameter int S        = 32,
  parameter int N        = 4,
  parameter int ACT      = 1,
  parameter int USE_BIAS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [S*N-1:0] x,
  input  logic [S*N-1:0] bias,
  output logic [S*N-1:0] y,
  output logic           busy,
  output logic           done,
  output logic           nan_flag,
  output logic           ovf_flag
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [S*N-1:0] x_q, x_d, bias_q, bias_d, y_q, y_d;
  logic [S-1:0]   sum_q, sum_d;
  logic           busy_q, busy_d, done_q, done_d, nan_q, nan_d, ovf_q, ovf_d;

  logic [S-1:0] x_elem, b_elem, act_in, act_out, add_sum;
  logic         add_rst_n, add_start, add_done, add_nan, add_ovf;

  assign x_elem    = `BA_ELEM(x_q, k_q, S, N);
  assign b_elem    = `BA_ELEM(bias_q, k_q, S, N);
  assign act_in    = (USE_BIAS != 0) ? sum_q : x_elem;
  // The adder is cleared before every element so no stale done can leak in.
  assign add_rst_n = !(rst || (state_q == S_ISSUE));
  assign add_start = (state_q == S_ARM);

  if (USE_BIAS != 0) begin : g_adder
    add_float #(.S(S)) u_add (
      .clk      (clk),
      .rst_n    (add_rst_n),
      .start    (add_start),
      .sub      (1'b0),
      .a        (x_elem),
      .b        (b_elem),
      .sum      (add_sum),
      .done     (add_done),
      .nan      (add_nan),
      .overflow (add_ovf)
    );
  end else begin : g_no_adder
    assign add_sum  = '0;
    assign add_done = 1'b0;
    assign add_nan  = 1'b0;
    assign add_ovf  = 1'b0;
  end

  if (ACT == ACT_RELU) begin : g_relu
    float_relu #(.S(S)) u_relu (
      .v (act_in),
      .r (act_out)
    );
  end else begin : g_ident
    assign act_out = act_in;
  end

  // Next-state and datapath updates for the element walk.
  always_comb begin
    state_d = state_q; k_d = k_q; x_d = x_q; bias_d = bias_q; y_d = y_q;
    sum_d = sum_q; busy_d = busy_q; done_d = done_q; nan_d = nan_q; ovf_d = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d     = x;
          bias_d  = bias;
          y_d     = '0;
          k_d     = '0;
          nan_d   = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = (USE_BIAS != 0) ? S_ISSUE : S_WRITE;
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM:   state_d = S_WAIT;
      S_WAIT: begin
        if (add_done) begin
          sum_d   = add_sum;
          nan_d   = nan_q | add_nan;
          ovf_d   = ovf_q | add_ovf;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        `BA_ELEM(y_d, k_q, S, N) = act_out;
        if (k_q == KW'(N - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = (USE_BIAS != 0) ? S_ISSUE : S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state flops; reset aborts any pass and drops partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; k_q <= '0; x_q <= '0; bias_q <= '0; y_q <= '0;
      sum_q <= '0; busy_q <= 1'b0; done_q <= 1'b0; nan_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      state_q <= state_d; k_q <= k_d; x_q <= x_d; bias_q <= bias_d; y_q <= y_d;
      sum_q <= sum_d; busy_q <= busy_d; done_q <= done_d; nan_q <= nan_d; ovf_q <= ovf_d;
    end
  end

  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nan_flag = nan_q;
  assign ovf_flag = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bias_activate.sv
// ============================================================================
// tb_bias_activate
// Scoreboard bench: ReLU+bias, identity+bias and ReLU-bypass instances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bias_activate;

  localparam int S = 32;
  localparam int N = 4;
  localparam int W = S * N;

  localparam logic [W-1:0] ALL  = '1;
  localparam logic [W-1:0] XB   = {32'h3F800000, 32'hC0000000, 32'h3F000000, 32'h40400000};
  localparam logic [W-1:0] BB   = {4{32'h3F000000}};
  localparam logic [W-1:0] Y_RA = {32'h3FC00000, 32'h00000000, 32'h3F800000, 32'h40600000};
  localparam logic [W-1:0] Y_ID = {32'h3FC00000, 32'hBFC00000, 32'h3F800000, 32'h40600000};
  localparam logic [W-1:0] Y_BP = {32'h3F800000, 32'h00000000, 32'h3F000000, 32'h40400000};
  localparam logic [W-1:0] XE   = {32'h80000000, 32'h7FC00000, 32'h7F7FFFFF, 32'h3F800000};
  localparam logic [W-1:0] BE   = {32'h00000000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000};
  localparam logic [W-1:0] Y_E  = {32'h00000000, 32'h00000000, 32'h7F800000, 32'h40000000};
  localparam logic [W-1:0] M_E  = {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] mask;
    logic         nan;
    logic         ovf;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [W-1:0]       x, bias;
  logic [2:0]         start;
  logic [2:0][W-1:0]  y_v;
  logic [2:0]         busy_v, done_v, nan_v, ovf_v;

  exp_t sb[$];
  int   n_checks, n_pass;

  bias_activate #(.S(S), .N(N), .ACT(1), .USE_BIAS(1)) dut_ra (
    .clk(clk), .rst(rst), .start(start[0]), .x(x), .bias(bias), .y(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .nan_flag(nan_v[0]), .ovf_flag(ovf_v[0]));

  bias_activate #(.S(S), .N(N), .ACT(0), .USE_BIAS(1)) dut_id (
    .clk(clk), .rst(rst), .start(start[1]), .x(x), .bias(bias), .y(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .nan_flag(nan_v[1]), .ovf_flag(ovf_v[1]));

  bias_activate #(.S(S), .N(N), .ACT(1), .USE_BIAS(0)) dut_bp (
    .clk(clk), .rst(rst), .start(start[2]), .x(x), .bias(bias), .y(y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .nan_flag(nan_v[2]), .ovf_flag(ovf_v[2]));

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Drive one pass on instance d, optionally pulsing start again at cycle glitch.
  task automatic run_pass(input int d, input logic [W-1:0] xi, input logic [W-1:0] bi,
                          input logic [W-1:0] ey, input logic [W-1:0] em,
                          input logic en, input logic eo, input int lat, input int glitch);
    exp_t e;
    int   cyc;
    logic busy_ok;
    e.y = ey; e.mask = em; e.nan = en; e.ovf = eo; e.lat = lat;
    sb.push_back(e);
    x = xi; bias = bi; start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    x = ~xi; bias = ~bi;
    cyc = 1;
    check("first_busy", busy_v[d], 1'b1);
    check("first_done", done_v[d], 1'b0);
    check("first_y", y_v[d], '0);
    check("first_flags", {nan_v[d], ovf_v[d]}, 2'b00);
    busy_ok = 1'b1;
    while (!done_v[d] && cyc < 200) begin
      if (!busy_v[d]) busy_ok = 1'b0;
      if (cyc == glitch) begin
        start[d] = 1'b1;
        x = '0;
      end
      @(posedge clk); #1;
      start[d] = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    if (!done_v[d]) begin
      check("timeout", 1'b0, 1'b1);
    end else begin
      check("busy_during", busy_ok, 1'b1);
      check("latency", cyc, e.lat);
      check("busy_at_done", busy_v[d], 1'b0);
      check("y", y_v[d] & e.mask, e.y & e.mask);
      check("nan_flag", nan_v[d], e.nan);
      check("ovf_flag", ovf_v[d], e.ovf);
    end
  endtask

  logic [S-1:0] e1;
  int           cyc;

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; start = '0; x = '0; bias = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_y", y_v[0], '0);
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_done", done_v[0], 1'b0);
    check("rst_flags", {nan_v[0], ovf_v[0]}, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;

    run_pass(0, XB, BB, Y_RA, ALL, 1'b0, 1'b0, 21, -1);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", done_v[0], 1'b1);
    check("y_hold", y_v[0], Y_RA);

    run_pass(1, XB, BB, Y_ID, ALL, 1'b0, 1'b0, 21, -1);

    run_pass(0, XE, BE, Y_E, M_E, 1'b1, 1'b1, 21, -1);
    e1 = y_v[0][S*(N-2) +: S];
    check("nan_elem", ((&e1[30:23]) && (|e1[22:0])), 1'b1);

    // Clean run that also clears the sticky flags; a stray start mid-pass.
    run_pass(0, XB, BB, Y_RA, ALL, 1'b0, 1'b0, 21, 7);

    // Reset while element 2 waits on the adder.
    x = XB; bias = BB; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    cyc = 1;
    while (cyc < 13) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("partial_y", y_v[0], {32'h3FC00000, 32'h00000000, 64'h0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_y", y_v[0], '0);
    check("abort_busy", busy_v[0], 1'b0);
    check("abort_done", done_v[0], 1'b0);
    run_pass(0, XB, BB, Y_RA, ALL, 1'b0, 1'b0, 21, -1);

    run_pass(2, XB, BB, Y_BP, ALL, 1'b0, 1'b0, 5, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
